// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             IF_ID_valid;
    logic [XLEN-1:0]  IF_ID_pc;
    logic [XLEN-1:0]  IF_ID_rs1_data;
    logic [XLEN-1:0]  IF_ID_rs2_data;
    logic [XLEN-1:0]  IF_ID_imm;
    logic [4:0]       IF_ID_rs1;
    logic [4:0]       IF_ID_rs2;
    logic [4:0]       IF_ID_rd;
    logic [1:0]       IF_ID_use;
    logic [7:0]       IF_ID_ctrl;
    logic             EX_flush;
    logic             ID_EX_valid;
    logic [XLEN-1:0]  ID_EX_pc;
    logic [XLEN-1:0]  ID_EX_rs1_data;
    logic [XLEN-1:0]  ID_EX_rs2_data;
    logic [XLEN-1:0]  ID_EX_imm;
    logic [4:0]       ID_EX_rs1;
    logic [4:0]       ID_EX_rs2;
    logic [4:0]       ID_EX_rd;
    logic [7:0]       ID_EX_ctrl;
    logic             stall;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IF_ID_valid, IF_ID_pc, IF_ID_rs1_data, IF_ID_rs2_data, IF_ID_imm,
               IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_use, IF_ID_ctrl, EX_flush,
        input  ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_ctrl, stall, stall_count, flush_count
    );

    modport slave (
        input  IF_ID_valid, IF_ID_pc, IF_ID_rs1_data, IF_ID_rs2_data, IF_ID_imm,
               IF_ID_rs1, IF_ID_rs2, IF_ID_rd, IF_ID_use, IF_ID_ctrl, EX_flush,
        output ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
               ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_ctrl, stall, stall_count, flush_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, branch flush and perf counters
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic            hazard;
    logic            bubble;
    logic            nxt_valid;
    logic [XLEN-1:0] nxt_pc;
    logic [XLEN-1:0] nxt_rs1_data;
    logic [XLEN-1:0] nxt_rs2_data;
    logic [XLEN-1:0] nxt_imm;
    logic [4:0]      nxt_rs1;
    logic [4:0]      nxt_rs2;
    logic [4:0]      nxt_rd;
    logic [7:0]      nxt_ctrl;

    assign hazard = bus.ID_EX_valid & bus.ID_EX_ctrl[5] & (bus.ID_EX_rd != 5'd0) & bus.IF_ID_valid &
                    ((bus.IF_ID_use[0] & (bus.IF_ID_rs1 == bus.ID_EX_rd)) |
                     (bus.IF_ID_use[1] & (bus.IF_ID_rs2 == bus.ID_EX_rd)));
    assign bus.stall = hazard & ~bus.EX_flush;
    assign bubble    = bus.EX_flush | bus.stall;

    // A flush or stall turns EX into an all-zero NOP; otherwise take ID's instruction
    always_comb begin
        nxt_valid    = ~bubble & bus.IF_ID_valid;
        nxt_pc       = bubble ? '0 : bus.IF_ID_pc;
        nxt_rs1_data = bubble ? '0 : bus.IF_ID_rs1_data;
        nxt_rs2_data = bubble ? '0 : bus.IF_ID_rs2_data;
        nxt_imm      = bubble ? '0 : bus.IF_ID_imm;
        nxt_rs1      = bubble ? '0 : bus.IF_ID_rs1;
        nxt_rs2      = bubble ? '0 : bus.IF_ID_rs2;
        nxt_rd       = bubble ? '0 : bus.IF_ID_rd;
        nxt_ctrl     = nxt_valid ? bus.IF_ID_ctrl : '0;
    end

    // Pipeline register; reset leaves a NOP in EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ID_EX_valid    <= 1'b0;
            bus.ID_EX_pc       <= '0;
            bus.ID_EX_rs1_data <= '0;
            bus.ID_EX_rs2_data <= '0;
            bus.ID_EX_imm      <= '0;
            bus.ID_EX_rs1      <= '0;
            bus.ID_EX_rs2      <= '0;
            bus.ID_EX_rd       <= '0;
            bus.ID_EX_ctrl     <= '0;
        end else begin
            bus.ID_EX_valid    <= nxt_valid;
            bus.ID_EX_pc       <= nxt_pc;
            bus.ID_EX_rs1_data <= nxt_rs1_data;
            bus.ID_EX_rs2_data <= nxt_rs2_data;
            bus.ID_EX_imm      <= nxt_imm;
            bus.ID_EX_rs1      <= nxt_rs1;
            bus.ID_EX_rs2      <= nxt_rs2;
            bus.ID_EX_rd       <= nxt_rd;
            bus.ID_EX_ctrl     <= nxt_ctrl;
        end
    end

    // Saturating stall/flush cycle counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.stall_count <= '0;
            bus.flush_count <= '0;
        end else begin
            if (bus.stall && bus.stall_count != CNT_MAX) bus.stall_count <= bus.stall_count + CNT_ONE;
            if (bus.EX_flush && bus.flush_count != CNT_MAX) bus.flush_count <= bus.flush_count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a reference model
module tb_id_ex_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 10;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_pass = 0;

    logic        m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [7:0]  m_ctrl;
    int          sc, fc;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic m_clear();
        m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
    endtask

    function automatic bit m_hazard();
        return m_valid && m_ctrl[5] && m_rd != 0 && bus.IF_ID_valid &&
               ((bus.IF_ID_use[0] && bus.IF_ID_rs1 == m_rd) || (bus.IF_ID_use[1] && bus.IF_ID_rs2 == m_rd));
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, d1, d2, imm,
                         input logic [4:0] rs1, rs2, rd, input logic [1:0] u,
                         input logic [7:0] ctrl, input bit fl);
        @(negedge clk);
        bus.IF_ID_valid = v; bus.IF_ID_pc = pc; bus.IF_ID_rs1_data = d1; bus.IF_ID_rs2_data = d2;
        bus.IF_ID_imm = imm; bus.IF_ID_rs1 = rs1; bus.IF_ID_rs2 = rs2; bus.IF_ID_rd = rd;
        bus.IF_ID_use = u; bus.IF_ID_ctrl = ctrl; bus.EX_flush = fl;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, bus.ID_EX_valid, m_valid);
        check({tag, ".pc"}, bus.ID_EX_pc, m_pc);
        check({tag, ".d1"}, bus.ID_EX_rs1_data, m_d1);
        check({tag, ".d2"}, bus.ID_EX_rs2_data, m_d2);
        check({tag, ".imm"}, bus.ID_EX_imm, m_imm);
        check({tag, ".rs1"}, bus.ID_EX_rs1, m_rs1);
        check({tag, ".rs2"}, bus.ID_EX_rs2, m_rs2);
        check({tag, ".rd"}, bus.ID_EX_rd, m_rd);
        check({tag, ".ctrl"}, bus.ID_EX_ctrl, m_ctrl);
        check({tag, ".scnt"}, bus.stall_count, sc);
        check({tag, ".fcnt"}, bus.flush_count, fc);
    endtask

    task automatic step(input string tag);
        bit st;
        st = m_hazard() && !bus.EX_flush;
        #1 check({tag, ".stall"}, bus.stall, st);
        @(posedge clk);
        if (bus.EX_flush && fc < MAXC) fc++;
        if (st && sc < MAXC) sc++;
        if (bus.EX_flush || st) m_clear();
        else begin
            m_valid = bus.IF_ID_valid; m_pc = bus.IF_ID_pc; m_d1 = bus.IF_ID_rs1_data;
            m_d2 = bus.IF_ID_rs2_data; m_imm = bus.IF_ID_imm; m_rs1 = bus.IF_ID_rs1;
            m_rs2 = bus.IF_ID_rs2; m_rd = bus.IF_ID_rd;
            m_ctrl = bus.IF_ID_valid ? bus.IF_ID_ctrl : 8'h00;
        end
        #1 check_state(tag);
    endtask

    initial begin
        logic [4:0] nf_lrd [3] = '{5'd0, 5'd5, 5'd5};
        logic [4:0] nf_rs1 [3] = '{5'd0, 5'd5, 5'd6};
        logic [1:0] nf_use [3] = '{2'b01, 2'b00, 2'b11};
        m_clear(); sc = 0; fc = 0;
        bus.IF_ID_valid = 1; bus.IF_ID_pc = 32'h55; bus.IF_ID_rs1_data = 1; bus.IF_ID_rs2_data = 2;
        bus.IF_ID_imm = 3; bus.IF_ID_rs1 = 1; bus.IF_ID_rs2 = 2; bus.IF_ID_rd = 3;
        bus.IF_ID_use = 2'b11; bus.IF_ID_ctrl = 8'hFF; bus.EX_flush = 0;
        repeat (2) @(negedge clk);
        check_state("rst0");
        check("rst0.stall", bus.stall, 0);
        reset = 0;

        drive(1, 32'h100, 32'h11, 32'h22, 32'h4, 5'd1, 5'd2, 5'd5, 2'b11, 8'h80, 0);
        step("pass");
        check("pass.pc_const", bus.ID_EX_pc, 32'h100);
        check("pass.rd_const", bus.ID_EX_rd, 5);
        check("pass.ctrl_const", bus.ID_EX_ctrl, 8'h80);
        check("pass.valid_const", bus.ID_EX_valid, 1);

        drive(1, 32'h104, 32'h0, 32'h0, 32'h8, 5'd2, 5'd0, 5'd5, 2'b01, 8'hE4, 0);
        step("lu.lw");
        drive(1, 32'h108, 32'h7, 32'h9, 32'h0, 5'd5, 5'd7, 5'd6, 2'b11, 8'h80, 0);
        #1 check("lu.stall_const", bus.stall, 1);
        step("lu.bub");
        check("lu.bub_valid", bus.ID_EX_valid, 0);
        check("lu.bub_ctrl", bus.ID_EX_ctrl, 0);
        drive(1, 32'h108, 32'h7, 32'h9, 32'h0, 5'd5, 5'd7, 5'd6, 2'b11, 8'h80, 0);
        step("lu.add");
        check("lu.add_pc", bus.ID_EX_pc, 32'h108);
        check("lu.scnt_const", bus.stall_count, 1);

        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200, 0, 0, 0, 5'd1, 5'd0, nf_lrd[i], 2'b01, 8'hE4, 0);
            step("nf.lw");
            drive(1, 32'h204 + i, 1, 2, 3, nf_rs1[i], 5'd7, 5'd9, nf_use[i], 8'h80, 0);
            step("nf.use");
            check("nf.pc_const", bus.ID_EX_pc, 32'h204 + i);
            check("nf.scnt_const", bus.stall_count, 1);
        end

        drive(1, 32'h300, 0, 0, 0, 5'd1, 5'd0, 5'd5, 2'b01, 8'hE4, 0);
        step("fh.lw");
        drive(1, 32'h304, 1, 2, 3, 5'd5, 5'd5, 5'd8, 2'b11, 8'h80, 1);
        step("fh");
        check("fh.fcnt_const", bus.flush_count, 1);
        check("fh.scnt_const", bus.stall_count, 1);
        check("fh.valid_const", bus.ID_EX_valid, 0);

        drive(1, 32'h400, 0, 0, 0, 5'd1, 5'd0, 5'd5, 2'b01, 8'hE4, 0);
        step("rms.lw");
        drive(1, 32'h404, 1, 2, 3, 5'd5, 5'd0, 5'd8, 2'b01, 8'h80, 0);
        #1 check("rms.stall_pre", bus.stall, 1);
        #2 reset = 1;
        #1;
        m_clear(); sc = 0; fc = 0;
        check("rms.stall", bus.stall, 0);
        check_state("rms");
        @(negedge clk) reset = 0;

        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom) | ($urandom_range(0, 1) != 0 ? 8'h20 : 8'h00),
                  $urandom_range(0, 7) == 0);
            step("rnd");
        end

        for (int i = 0; i < MAXC + 4; i++) begin
            drive(1, 32'h500, 0, 0, 0, 5'd1, 5'd0, 5'd5, 2'b01, 8'hE4, 0);
            step("ss.lw");
            drive(1, 32'h504, 0, 0, 0, 5'd5, 5'd0, 5'd6, 2'b01, 8'h80, 0);
            step("ss.use");
        end
        check("ss.sat", bus.stall_count, MAXC);

        for (int i = 0; i < MAXC + 4; i++) begin
            drive(1, $urandom, 0, 0, 0, 5'd1, 5'd2, 5'd3, 2'b11, 8'hE4, 1);
            step("fs");
        end
        check("fs.sat", bus.flush_count, MAXC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
